// File: rtl/serializer_arb.sv
// serializer_arb
// Round-robin arbiter that lets REQ_CNT requesters share one bit serializer.
// A requester's word is accepted in IDLE, issued to the serializer as a
// single-cycle strobe, and then the block waits for the serializer to go busy
// and come back idle. It gives up if the serializer never starts.
// A word whose bit count is 1 or 2 is accepted but discarded.
//
// Ports
//   clk_i           rising-edge clock
//   srst_i          synchronous active-high reset
//   req_data_i      packed per-requester words, requester k at [k*DATA_W +: DATA_W]
//   req_data_mod_i  packed per-requester bit counts (MSB-first, 0 = all bits)
//   req_data_val_i  per-requester request valid
//   req_ready_o     one-hot accept, combinational, only in IDLE
//   ser_busy_i      serializer busy flag
//   data_o          word presented to the serializer
//   data_mod_o      bit count presented to the serializer
//   data_val_o      one-cycle issue strobe
//   grant_id_o      index of the requester owning the current transfer
//   drop_o          one-cycle pulse: accepted word discarded
//   timeout_o       one-cycle pulse: serializer never went busy after issue
module serializer_arb #(
    parameter int REQ_CNT  = 4,
    parameter int DATA_W   = 16,
    parameter int START_TO = 2,
    localparam int MOD_W   = $clog2(DATA_W),
    localparam int ID_W    = $clog2(REQ_CNT)
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [REQ_CNT*DATA_W-1:0] req_data_i,
    input  logic [REQ_CNT*MOD_W-1:0]  req_data_mod_i,
    input  logic [REQ_CNT-1:0]        req_data_val_i,
    output logic [REQ_CNT-1:0]        req_ready_o,
    input  logic                      ser_busy_i,
    output logic [DATA_W-1:0]         data_o,
    output logic [MOD_W-1:0]          data_mod_o,
    output logic                      data_val_o,
    output logic [ID_W-1:0]           grant_id_o,
    output logic                      drop_o,
    output logic                      timeout_o
);

    localparam int TO_W = $clog2(START_TO + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE      = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [DATA_W-1:0]   data_r;
    logic [MOD_W-1:0]    mod_r;
    logic [ID_W-1:0]     grant_r;
    logic                data_val_r;
    logic                drop_r;
    logic                timeout_r;
    logic [TO_W-1:0]     to_cnt_r;

    logic [ID_W:0]       pick_s;
    logic                found_s;
    logic [ID_W-1:0]     win_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [MOD_W-1:0]    sel_mod_s;
    logic                illegal_s;
    logic                accept_s;
    logic                to_fire_s;
    logic [REQ_CNT-1:0]  ready_s;

    // Returns {found, index}: first valid requester at or after ptr, wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [REQ_CNT-1:0] val,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   res;
        logic            found;
        logic [ID_W-1:0] idx;
        res   = {(ID_W+1){1'b0}};
        found = 1'b0;
        for (int i = 0; i < REQ_CNT; i++) begin
            idx = ID_W'((int'(ptr) + i) % REQ_CNT);
            if (!found && val[idx]) begin
                found = 1'b1;
                res   = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Winner selection and AND-OR mux of the winner's word and bit count.
    always_comb begin
        pick_s     = rr_pick(req_data_val_i, rr_ptr_r);
        found_s    = pick_s[ID_W];
        win_s      = pick_s[ID_W-1:0];
        sel_data_s = {DATA_W{1'b0}};
        sel_mod_s  = {MOD_W{1'b0}};
        for (int k = 0; k < REQ_CNT; k++) begin
            sel_data_s = sel_data_s |
                (req_data_i[k*DATA_W +: DATA_W] & {DATA_W{win_s == ID_W'(k)}});
            sel_mod_s  = sel_mod_s |
                (req_data_mod_i[k*MOD_W +: MOD_W] & {MOD_W{win_s == ID_W'(k)}});
        end
        // Counts of 1 or 2 bits are not supported by the serializer.
        illegal_s = (sel_mod_s == MOD_W'(1)) || (sel_mod_s == MOD_W'(2));
    end

    // FSM next-state logic and accept handshake; reset suppresses any accept.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        to_fire_s   = 1'b0;
        ready_s     = {REQ_CNT{1'b0}};
        case (state_r)
            IDLE: begin
                if (found_s && !srst_i) begin
                    accept_s    = 1'b1;
                    ready_s     = REQ_CNT'(1) << win_s;
                    state_nxt_s = illegal_s ? IDLE : ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT_START;
            end
            WAIT_START: begin
                if (ser_busy_i) begin
                    state_nxt_s = WAIT_DONE;
                end else if (to_cnt_r == TO_W'(START_TO - 1)) begin
                    to_fire_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_START;
                end
            end
            WAIT_DONE: begin
                if (!ser_busy_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers: captured word, grant, round-robin pointer, pulses.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            rr_ptr_r   <= {ID_W{1'b0}};
            data_r     <= {DATA_W{1'b0}};
            mod_r      <= {MOD_W{1'b0}};
            grant_r    <= {ID_W{1'b0}};
            data_val_r <= 1'b0;
            drop_r     <= 1'b0;
            timeout_r  <= 1'b0;
            to_cnt_r   <= {TO_W{1'b0}};
        end else begin
            data_val_r <= 1'b0;
            drop_r     <= 1'b0;
            timeout_r  <= to_fire_s;
            if (accept_s) begin
                data_r     <= sel_data_s;
                mod_r      <= sel_mod_s;
                grant_r    <= win_s;
                rr_ptr_r   <= (win_s == ID_W'(REQ_CNT - 1)) ? {ID_W{1'b0}}
                                                            : win_s + ID_W'(1);
                drop_r     <= illegal_s;
                data_val_r <= !illegal_s;
            end
            // Counter runs only while staying in WAIT_START.
            if (state_r == WAIT_START && state_nxt_s == WAIT_START) begin
                to_cnt_r <= to_cnt_r + TO_W'(1);
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
        end
    end

    assign req_ready_o = ready_s;
    assign data_o      = data_r;
    assign data_mod_o  = mod_r;
    assign grant_id_o  = grant_r;
    // The strobe is masked if the serializer is already busy.
    assign data_val_o  = data_val_r & ~ser_busy_i;
    assign drop_o      = drop_r;
    assign timeout_o   = timeout_r;

endmodule

// File: doc/serializer_arb.md
SERIALIZER_ARB -- requirements
Module: serializer_arb

Interface
REQ-001 Parameter REQ_CNT, default 4, number of requesters sharing one serializer.
REQ-002 Parameter DATA_W, default 16, word width; MOD_W = $clog2(DATA_W) (4 at default); ID_W = $clog2(REQ_CNT).
REQ-003 Parameter START_TO, default 2, cycles allowed between issue and ser_busy_i rising.
REQ-004 clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 srst_i  input  1  synchronous, active-high reset.
REQ-006 req_data_i  input  REQ_CNT*DATA_W  per-requester word, requester k at bits [k*DATA_W +: DATA_W].
REQ-007 req_data_mod_i  input  REQ_CNT*MOD_W  per-requester valid-bit count, MSB-first; 0 means all DATA_W bits.
REQ-008 req_data_val_i  input  REQ_CNT  per-requester request valid.
REQ-009 req_ready_o  output  REQ_CNT  one-hot accept; a word transfers on val&ready in the same cycle.
REQ-010 ser_busy_i  input  1  serializer busy flag.
REQ-011 data_o  output  DATA_W  word to serializer.
REQ-012 data_mod_o  output  MOD_W  bit count to serializer.
REQ-013 data_val_o  output  1  one-cycle issue strobe to serializer.
REQ-014 grant_id_o  output  ID_W  index of requester owning the current transfer.
REQ-015 drop_o  output  1  one-cycle pulse: accepted word discarded (illegal mod).
REQ-016 timeout_o  output  1  one-cycle pulse: serializer never went busy after issue.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
REQ-018 IDLE: if any req_data_val_i, winner = first valid requester at or after rr_ptr, modulo REQ_CNT; req_ready_o is one-hot on the winner, combinational, in IDLE only.
REQ-019 req_ready_o is all-zero in every state except IDLE.
REQ-020 On accept: data, mod and winner index registered; rr_ptr <= winner+1 (wraps REQ_CNT-1 -> 0).
REQ-021 Accepted mod 1 or 2: word discarded, drop_o = 1 next cycle, FSM stays IDLE, grant_id_o = winner; no data_val_o.
REQ-022 Any other mod: IDLE -> ISSUE; in ISSUE, data_val_o = 1 for exactly one cycle with the registered data_o/data_mod_o; ISSUE -> WAIT_START.
REQ-023 Latency: accept at cycle T -> data_val_o high at T+1.
REQ-024 WAIT_START: ser_busy_i = 1 -> WAIT_DONE; START_TO cycles without busy -> timeout_o pulse, -> IDLE.
REQ-025 WAIT_DONE: ser_busy_i = 0 -> IDLE; next accept is possible in that IDLE cycle.
REQ-026 data_o, data_mod_o and grant_id_o hold their values from accept until the next accept.
REQ-027 data_val_o is never asserted while ser_busy_i = 1 or outside ISSUE.
REQ-028 Requesters not granted keep their request pending; no request is lost or reordered per requester.
REQ-029 Fairness: with all REQ_CNT requesters continuously valid, each is granted exactly once per REQ_CNT grants.
REQ-030 Deasserting req_data_val_i outside IDLE has no effect on the transfer in progress.

Reset
REQ-031 srst_i sampled high -> FSM IDLE, rr_ptr = 0, and every output low: req_ready_o, data_o, data_mod_o, data_val_o, grant_id_o, drop_o, timeout_o.
REQ-032 srst_i mid-transfer (any state) aborts it at the next edge; no data_val_o is issued after reset.
REQ-033 srst_i has priority over every other input in the same cycle.

Verification
REQ-034 Single requester: req1 data 16'hCA00, mod 7, val held -> ready[1] at T, data_val_o at T+1 with 16'hCA00/7, grant_id_o = 1; busy 1 for 7 cycles then 0 -> FSM back in IDLE.
REQ-035 All four requesters valid continuously, busy model 16 cycles -> grant order 0,1,2,3,0; each ready pulse one cycle.
REQ-036 req2 mod 1, then mod 2 -> drop_o pulses twice, data_val_o stays 0, rr_ptr advances to 3 after each drop.
REQ-037 Serializer busy held 0 after issue -> timeout_o pulse START_TO cycles after WAIT_START entry; next request accepted afterwards.
REQ-038 srst_i asserted in WAIT_DONE with req0 and req3 valid -> all outputs 0 next cycle; after release req0 is granted first.
REQ-039 Mod 0 word 16'hFFFF from req3 while req0 arrives during WAIT_DONE -> req3 issued with mod 0; req0 accepted in the first IDLE cycle after busy falls.
